siso_tx_sched: RTL and testbench

Round-robin scheduler and serialiser controller that shares one serial output lane between NUM_REQ parallel-word requesters.
- Accepts one W-bit word per frame over a valid/ready handshake.
- Frames each word as a start bit followed by W data bits, MSB first (left-shift order), then GAP idle cycles.
- All sequencing advances on a bit-rate enable, so the lane runs slower than clk when needed.

---
 rtl/siso_tx_sched_pkg.sv | 11 +
 rtl/siso_tx_sched_rr_arbiter.sv | 36 +++
 rtl/siso_tx_sched.sv | 123 ++++++++++++
 tb/tb_siso_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_tx_sched_pkg.sv
// Shared types and sizing helpers for the serial TX scheduler.
package siso_pkg;

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} tx_state_t;

  // Index width that stays at least one bit wide for tiny n.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/siso_tx_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after 'start' (wrapping) wins.
module rr_arbiter
  import siso_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(start) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (en && !found && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/siso_tx_sched.sv
// Shares one serial lane between NUM_REQ word requesters; frames are
// start bit + W data bits MSB first + GAP idle bit-times, paced by en.
module siso_tx_sched
  import siso_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned W       = 8,
  parameter  int unsigned GAP     = 1,
  localparam int unsigned IW      = clog2_min1(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic                 frame_done
);

  localparam int unsigned CW = clog2_min1(W);
  localparam int unsigned GW = clog2_min1(GAP + 1);

  tx_state_t     state;
  logic [W-1:0]  shreg;
  logic [CW-1:0] bitcnt;
  logic [GW-1:0] gapcnt;
  logic          started;
  logic [IW-1:0] start_idx;
  logic [IW-1:0] win_idx;
  logic [NUM_REQ-1:0] win;
  logic          arb_en;
  logic [W-1:0]  words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*W +: W];
  end

  // Until the first grant after reset, requester 0 has top priority.
  always_comb begin
    start_idx = '0;
    if (started && grant_id != IW'(NUM_REQ - 1))
      start_idx = grant_id + IW'(1);
  end

  // frame_done still high in IDLE marks the drain bit-time of a gapless frame.
  assign arb_en    = (state == IDLE) && en && !frame_done && !rst;
  assign req_ready = win;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .start (start_idx),
    .en    (arb_en),
    .grant (win),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      started    <= 1'b0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (|win) begin
            shreg      <= words[win_idx];
            grant_id   <= win_idx;
            started    <= 1'b1;
            serial_out <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end else begin
            serial_out <= 1'b0;
            frame_done <= 1'b0;
          end
        end
        START: begin
          serial_out <= shreg[W-1];
          shreg      <= {shreg[W-2:0], 1'b0};
          bitcnt     <= CW'(W - 1);
          state      <= SHIFT;
        end
        SHIFT: begin
          serial_out <= shreg[W-1];
          shreg      <= {shreg[W-2:0], 1'b0};
          if (bitcnt == CW'(1)) begin
            bitcnt     <= '0;
            frame_done <= 1'b1;
            if (GAP != 0) begin
              gapcnt <= '0;
              state  <= siso_pkg::GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            bitcnt <= bitcnt - CW'(1);
          end
        end
        siso_pkg::GAP: begin
          if (gapcnt == GW'(GAP)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            serial_out <= 1'b0;
            frame_done <= 1'b0;
            gapcnt     <= gapcnt + GW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_tx_sched.sv
// Directed bench: main instance (GAP=1) plus a GAP=0 instance.
module tb_siso_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_data;
  logic        serial_out, busy, frame_done;
  logic [0:0]  grant_id;

  logic        en_b;
  logic [1:0]  req_valid_b, req_ready_b;
  logic [15:0] req_data_b;
  logic        serial_out_b, busy_b, frame_done_b;
  logic [0:0]  grant_id_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  siso_tx_sched #(.NUM_REQ(2), .W(8), .GAP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  siso_tx_sched #(.NUM_REQ(2), .W(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .serial_out(serial_out_b), .busy(busy_b),
    .grant_id(grant_id_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_data  = 16'hF0A5;
    tick();
    n_cmp++;
    if ({serial_out, busy, grant_id, frame_done, req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_main out=%b ready=%b exp all 0", {serial_out, busy, grant_id, frame_done}, req_ready);
    end
    n_cmp++;
    if ({serial_out_b, busy_b, grant_id_b, frame_done_b, req_ready_b} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_gap0 out=%b ready=%b exp all 0", {serial_out_b, busy_b, grant_id_b, frame_done_b}, req_ready_b);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    req_data  = 16'h00A5;
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_accept ready=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if ({serial_out, busy, grant_id, frame_done} !== 4'b1100) begin
      n_err++; $display("FAIL single_start ser/busy/gid/fd=%b exp=1100", {serial_out, busy, grant_id, frame_done});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (serial_out !== w[7-i] || frame_done !== (i == 7) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL single_bit%0d ser=%b fd=%b busy=%b exp ser=%b fd=%b busy=1", i, serial_out, frame_done, busy, w[7-i], (i == 7));
      end
    end
    tick();
    n_cmp++;
    if ({serial_out, frame_done, busy} !== 3'b001) begin
      n_err++; $display("FAIL single_gap ser/fd/busy=%b exp=001", {serial_out, frame_done, busy});
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_contention();
    int last, cnt, g;
    logic [7:0] w;
    last = 0;
    do_reset();
    req_data  = 16'hF00F;
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      g = f % 2;
      w = (g == 1) ? 8'hF0 : 8'h0F;
      cnt = 0;
      #1;
      while (req_ready === 2'b00 && cnt < 20) begin
        tick(); #1; cnt++;
      end
      n_cmp++;
      if (cnt >= 20) begin
        n_err++; $display("FAIL cont_timeout frame=%0d no accept within 20 cycles", f);
      end
      n_cmp++;
      if (req_ready !== 2'(1 << g)) begin
        n_err++; $display("FAIL cont_grant frame=%0d ready=%b exp=%b", f, req_ready, 2'(1 << g));
      end
      if (f > 0) begin
        n_cmp++;
        if (cyc - last !== 11) begin
          n_err++; $display("FAIL cont_spacing frame=%0d got=%0d exp=11", f, cyc - last);
        end
      end
      last = cyc;
      tick();
      n_cmp++;
      if (grant_id !== 1'(g) || serial_out !== 1'b1) begin
        n_err++; $display("FAIL cont_gid frame=%0d gid=%0d ser=%b exp gid=%0d ser=1", f, grant_id, serial_out, g);
      end
      for (int i = 0; i < 8; i++) begin
        tick();
        n_cmp++;
        if (serial_out !== w[7-i]) begin
          n_err++; $display("FAIL cont_bit frame=%0d bit=%0d ser=%b exp=%b", f, i, serial_out, w[7-i]);
        end
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stretch();
    logic [8:0] pat;
    pat = 9'h1C3;
    do_reset();
    en        = 1'b0;
    req_data  = 16'h00C3;
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL stretch_noaccept cyc=%0d ready=%b exp=00", i, req_ready);
      end
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL stretch_idle busy=%b exp=0", busy);
    end
    for (int i = 0; i <= 36; i++) begin
      en = (i % 4 == 0);
      #1;
      n_cmp++;
      if (i == 0) begin
        if (req_ready !== 2'b01) begin
          n_err++; $display("FAIL stretch_accept ready=%b exp=01", req_ready);
        end
      end else if (req_ready !== 2'b00 || serial_out !== pat[8 - (i-1)/4]) begin
        n_err++;
        $display("FAIL stretch_cyc%0d ready=%b ser=%b exp ready=00 ser=%b", i, req_ready, serial_out, pat[8 - (i-1)/4]);
      end
      tick();
    end
    en = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic test_reset_abort();
    do_reset();
    req_data  = 16'h00A5;
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL abort_accept ready=%b exp=01", req_ready);
    end
    for (int i = 0; i < 4; i++) tick();
    #2;
    n_cmp++;
    if (serial_out !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_pre ser=%b busy=%b exp 1 1", serial_out, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({serial_out, busy, frame_done, req_ready} !== 5'b0) begin
      n_err++; $display("FAIL abort_async ser/busy/fd=%b ready=%b exp 0", {serial_out, busy, frame_done}, req_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    req_data  = 16'hF0A5;
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL abort_regrant ready=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if (grant_id !== 1'b0 || serial_out !== 1'b1) begin
      n_err++; $display("FAIL abort_gid gid=%0d ser=%b exp gid=0 ser=1", grant_id, serial_out);
    end
  endtask

  task automatic test_gap0();
    logic [7:0] w;
    w = 8'h81;
    do_reset();
    req_data_b  = 16'h0081;
    req_valid_b = 2'b01;
    for (int f = 0; f < 2; f++) begin
      #1;
      n_cmp++;
      if (req_ready_b !== 2'b01) begin
        n_err++; $display("FAIL gap0_accept frame=%0d ready=%b exp=01", f, req_ready_b);
      end
      tick();
      n_cmp++;
      if (serial_out_b !== 1'b1 || busy_b !== 1'b1) begin
        n_err++; $display("FAIL gap0_start frame=%0d ser=%b busy=%b exp 1 1", f, serial_out_b, busy_b);
      end
      for (int i = 0; i < 8; i++) begin
        tick();
        n_cmp++;
        if (serial_out_b !== w[7-i] || frame_done_b !== (i == 7)) begin
          n_err++;
          $display("FAIL gap0_bit frame=%0d bit=%0d ser=%b fd=%b exp ser=%b fd=%b", f, i, serial_out_b, frame_done_b, w[7-i], (i == 7));
        end
      end
      n_cmp++;
      if (busy_b !== 1'b0 || req_ready_b !== 2'b00) begin
        n_err++; $display("FAIL gap0_last frame=%0d busy=%b ready=%b exp busy=0 ready=00", f, busy_b, req_ready_b);
      end
      tick();
      n_cmp++;
      if (serial_out_b !== 1'b0 || frame_done_b !== 1'b0) begin
        n_err++; $display("FAIL gap0_between frame=%0d ser=%b fd=%b exp 0 0", f, serial_out_b, frame_done_b);
      end
    end
    #1;
    n_cmp++;
    if (req_ready_b !== 2'b01) begin
      n_err++; $display("FAIL gap0_next ready=%b exp=01", req_ready_b);
    end
    req_valid_b = 2'b00;
  endtask

  task automatic test_lone();
    do_reset();
    req_data  = 16'h5A00;
    req_valid = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL lone_first ready=%b exp=10", req_ready);
    end
    tick();
    n_cmp++;
    if (grant_id !== 1'b1) begin
      n_err++; $display("FAIL lone_gid1 gid=%0d exp=1", grant_id);
    end
    for (int i = 0; i < 9; i++) tick();
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL lone_gapready ready=%b exp=00", req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL lone_regrant ready=%b exp=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if (grant_id !== 1'b1 || serial_out !== 1'b1) begin
      n_err++; $display("FAIL lone_gid2 gid=%0d ser=%b exp gid=1 ser=1", grant_id, serial_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    en_b        = 1'b1;
    req_valid   = 2'b00;
    req_data    = 16'h0000;
    req_valid_b = 2'b00;
    req_data_b  = 16'h0000;
    test_reset();
    test_single();
    test_contention();
    test_stretch();
    test_reset_abort();
    test_gap0();
    test_lone();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
